// File: rtl/scmp_mem_pkg.sv
// Shared types and page-window decode for the SC/MP board RAM arbiter.
// The CPU write-protection map lives here so the board top no longer carries it.
package scmp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_CYC,
    DBG_ISSUE,
    DBG_DATA
  } arb_state_t;

  localparam logic [7:0] IO_PAGE_DEF  = 8'h70;
  localparam logic [7:0] RAM_PAGE_DEF = 8'h77;
  localparam logic [3:0] ROM_HI_DEF   = 4'h7;

  // The 7xxx block is ROM apart from one scratch RAM page; the I/O page is never RAM.
  function automatic logic cpu_write_allowed(
    input logic [15:0] addr,
    input logic [7:0]  io_page,
    input logic [7:0]  ram_page,
    input logic [3:0]  rom_hi
  );
    logic ok;
    ok = (addr[15:12] != rom_hi) || (addr[15:8] == ram_page);
    if (addr[15:8] == io_page) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/scmp_mem_arbiter.sv
// Single owner of the board RAM port, shared between the SC/MP bus and a debug port.
// Debug gets its slot by holding off new CPU cycles; a stuck CPU cycle is cut off.
module scmp_mem_arbiter
  import scmp_mem_pkg::*;
#(
  parameter logic [7:0] IO_PAGE     = IO_PAGE_DEF,
  parameter logic [7:0] RAM_PAGE    = RAM_PAGE_DEF,
  parameter logic [3:0] ROM_HI      = ROM_HI_DEF,
  parameter int         CPU_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ads_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hold,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_ack,
  output logic [7:0]  dbg_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err
);

  localparam int CW = (CPU_TIMEOUT > 2) ? $clog2(CPU_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPU_TIMEOUT - 1);

  arb_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          strobe_seen_reg;
  logic          cpu_hold_reg;
  logic          dbg_ack_reg;
  logic [7:0]    dbg_rdata_reg;
  logic          bus_err_reg;
  logic          cpu_wr_ok;
  logic          cpu_idle_strobes;

  assign cpu_wr_ok        = cpu_write_allowed(cpu_addr, IO_PAGE, RAM_PAGE, ROM_HI);
  assign cpu_idle_strobes = cpu_ads_n & cpu_rd_n & cpu_wr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      strobe_seen_reg <= 1'b0;
      cpu_hold_reg    <= 1'b0;
      dbg_ack_reg     <= 1'b0;
      dbg_rdata_reg   <= 8'h00;
      bus_err_reg     <= 1'b0;
    end else begin
      dbg_ack_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
      // A request still high during its own ack cycle is the old one, not a new one.
      cpu_hold_reg <= dbg_req & ~dbg_ack_reg;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!cpu_ads_n) begin
            state_reg       <= CPU_CYC;
            strobe_seen_reg <= ~cpu_rd_n | ~cpu_wr_n;
          end else if (dbg_req && cpu_hold_reg) begin
            state_reg <= DBG_ISSUE;
          end
        end
        CPU_CYC: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bus_err_reg <= 1'b1;
          end else if (strobe_seen_reg && cpu_idle_strobes) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg         <= cnt_reg + CW'(1);
            strobe_seen_reg <= strobe_seen_reg | ~cpu_rd_n | ~cpu_wr_n;
          end
        end
        DBG_ISSUE: begin
          if (dbg_we) begin
            state_reg    <= IDLE;
            dbg_ack_reg  <= 1'b1;
            cpu_hold_reg <= 1'b0;
          end else begin
            state_reg <= DBG_DATA;
          end
        end
        DBG_DATA: begin
          state_reg     <= IDLE;
          dbg_rdata_reg <= mem_rdata;
          dbg_ack_reg   <= 1'b1;
          cpu_hold_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM port mux; reset parks it on the CPU address with writes suppressed.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE, CPU_CYC: mem_we = ~cpu_wr_n & cpu_wr_ok;
        DBG_ISSUE: begin
          mem_addr  = dbg_addr;
          mem_wdata = dbg_wdata;
          mem_we    = dbg_we;
        end
        DBG_DATA: begin
          mem_addr  = dbg_addr;
          mem_wdata = dbg_wdata;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_hold  = cpu_hold_reg;
  assign dbg_ack   = dbg_ack_reg;
  assign dbg_rdata = dbg_rdata_reg;
  assign bus_err   = bus_err_reg;

endmodule
